// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
//   Moore-style main control FSM for the multicycle RV32I core. Sequences the
//   write enables of the shared datapath registers (PC, IR/OldPC, ALUOut, Data,
//   register file) and drives the memory write strobe plus the ALU, address and
//   result multiplexer selects.
//
// Ports
//   clk         system clock, rising edge
//   resetn      asynchronous active-low reset
//   op          instr[6:0] from IR
//   funct3      instr[14:12] from IR (only bit 0 matters: BEQ/BNE)
//   zero        ALU zero flag (combinational)
//   pc_en       PC register enable
//   ir_en       IR and OldPC register enable
//   adr_src     memory address select: 0 = PC, 1 = ALUOut
//   mem_write   data memory write strobe
//   reg_write   register file write enable
//   alu_src_a   00 = PC, 01 = OldPC, 10 = rd1
//   alu_src_b   00 = rd2, 01 = ImmExt, 10 = constant 4
//   result_src  00 = ALUOut, 01 = Data, 10 = ALUResult
//   alu_op      00 = add, 01 = subtract, 10 = decode by funct
//   imm_src     immediate format select (000 I, 001 S, 010 B, 011 J)
//   illegal     one-cycle pulse in DECODE on an unsupported opcode
//   state_o     current state, for debug
module riscv_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               zero,
  output logic               pc_en,
  output logic               ir_en,
  output logic               adr_src,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_op,
  output logic [2:0]         imm_src,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BRANCH   = 4'd10
  } state_e;

  state_e state_q, state_d;

  logic pc_update, branch, ir_en_raw, mem_write_raw, reg_write_raw, illegal_raw;
  logic take;

  // Only funct3[0] distinguishes BEQ from BNE; the upper bits are intentionally ignored.
  logic unused_funct3;
  assign unused_funct3 = ^funct3[2:1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= FETCH;
    else         state_q <= state_d;
  end

  // Next state and state-decoded outputs; anything not set in a state stays idle.
  always_comb begin
    state_d       = FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_en_raw     = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      FETCH: begin
        ir_en_raw  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_JAL:            state_d = JAL;
          OP_BRANCH:         state_d = BRANCH;
          default: begin
            state_d     = FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Immediate format depends only on the opcode held in IR.
  always_comb begin
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: imm_src = 3'b000;
      OP_STORE:                   imm_src = 3'b001;
      OP_BRANCH:                  imm_src = 3'b010;
      OP_JAL:                     imm_src = 3'b011;
      default:                    imm_src = 3'b000;
    endcase
  end

  // Strobes are gated by resetn so that the FETCH enables stay low while reset is held.
  assign take      = zero ^ funct3[0];
  assign pc_en     = resetn & (pc_update | (branch & take));
  assign ir_en     = resetn & ir_en_raw;
  assign mem_write = resetn & mem_write_raw;
  assign reg_write = resetn & reg_write_raw;
  assign illegal   = resetn & illegal_raw;
  assign state_o   = STATE_W'(state_q);

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl
//   Directed self-checking bench for riscv_multicycle_ctrl. Walks lw, sw,
//   beq/bne, jal and an illegal opcode through the FSM, and applies reset in
//   the middle of a load, comparing outputs against hand-computed values.
module tb_riscv_multicycle_ctrl;

  logic       clk;
  logic       resetn;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       pc_en, ir_en, adr_src, mem_write, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state_o;

  int passCount;
  int checkCount;

  riscv_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .pc_en      (pc_en),
    .ir_en      (ir_en),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // Checks the state plus the four write strobes {pc_en, ir_en, mem_write, reg_write}.
  task automatic checkStep(input string tag, input logic [3:0] expState, input logic [3:0] expStrobes);
    checkOutput({tag, " state"}, 32'(state_o), 32'(expState));
    checkOutput({tag, " strobes"}, 32'({pc_en, ir_en, mem_write, reg_write}), 32'(expStrobes));
  endtask

  // Advances one clock and samples just after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    resetn     = 1'b0;
    op         = 7'b0000011;
    funct3     = 3'b000;
    zero       = 1'b0;

    #12;
    checkStep("reset hold", 4'd0, 4'b0000);
    checkOutput("reset alu_src_b", 32'(alu_src_b), 32'd2);
    checkOutput("reset result_src", 32'(result_src), 32'd2);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkStep("fetch after reset", 4'd0, 4'b1100);

    // lw: 0,1,2,3,4,0
    applyStimulus();
    checkStep("lw decode", 4'd1, 4'b0000);
    checkOutput("lw decode srcs", 32'({alu_src_a, alu_src_b, alu_op}), 32'b01_01_00);
    applyStimulus();
    checkStep("lw memadr", 4'd2, 4'b0000);
    checkOutput("lw memadr srcs", 32'({alu_src_a, alu_src_b}), 32'b10_01);
    applyStimulus();
    checkStep("lw memread", 4'd3, 4'b0000);
    checkOutput("lw memread adr_src", 32'(adr_src), 32'd1);
    applyStimulus();
    checkStep("lw memwb", 4'd4, 4'b0001);
    checkOutput("lw memwb result_src", 32'(result_src), 32'd1);
    applyStimulus();
    checkStep("lw back to fetch", 4'd0, 4'b1100);

    // Second lw, interrupted by reset in MEMREAD.
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkStep("lw2 memread", 4'd3, 4'b0000);
    #2;
    resetn = 1'b0;
    #1;
    checkStep("async reset mid-memread", 4'd0, 4'b0000);
    applyStimulus();
    checkStep("reset held 1", 4'd0, 4'b0000);
    applyStimulus();
    checkStep("reset held 2", 4'd0, 4'b0000);
    @(negedge clk);
    resetn = 1'b1;
    op     = 7'b0100011;
    #1;
    checkStep("fetch after release", 4'd0, 4'b1100);

    // sw: 0,1,2,5,0
    applyStimulus();
    checkStep("sw decode", 4'd1, 4'b0000);
    checkOutput("sw imm_src", 32'(imm_src), 32'd1);
    applyStimulus();
    checkStep("sw memadr", 4'd2, 4'b0000);
    applyStimulus();
    checkStep("sw memwrite", 4'd5, 4'b0010);
    checkOutput("sw memwrite adr_src", 32'(adr_src), 32'd1);
    applyStimulus();
    checkStep("sw back to fetch", 4'd0, 4'b1100);

    // beq: 0,1,10,0 with zero swept in BRANCH
    op     = 7'b1100011;
    funct3 = 3'b000;
    zero   = 1'b1;
    applyStimulus();
    checkStep("beq decode zero ignored", 4'd1, 4'b0000);
    checkOutput("beq imm_src", 32'(imm_src), 32'd2);
    applyStimulus();
    checkStep("beq taken", 4'd10, 4'b1000);
    checkOutput("beq alu_op", 32'({alu_src_a, alu_src_b, alu_op}), 32'b10_00_01);
    zero = 1'b0;
    #1;
    checkStep("beq not taken", 4'd10, 4'b0000);
    applyStimulus();
    checkStep("beq back to fetch", 4'd0, 4'b1100);

    // bne: results inverted
    funct3 = 3'b001;
    applyStimulus();
    applyStimulus();
    checkStep("bne taken", 4'd10, 4'b1000);
    zero = 1'b1;
    #1;
    checkStep("bne not taken", 4'd10, 4'b0000);
    applyStimulus();
    checkStep("bne back to fetch", 4'd0, 4'b1100);

    // jal: 0,1,9,7,0
    op     = 7'b1101111;
    funct3 = 3'b000;
    zero   = 1'b0;
    applyStimulus();
    checkStep("jal decode", 4'd1, 4'b0000);
    checkOutput("jal imm_src", 32'(imm_src), 32'd3);
    applyStimulus();
    checkStep("jal state", 4'd9, 4'b1000);
    checkOutput("jal srcs", 32'({alu_src_a, alu_src_b, alu_op}), 32'b01_10_00);
    applyStimulus();
    checkStep("jal aluwb", 4'd7, 4'b0001);
    checkOutput("jal aluwb result_src", 32'(result_src), 32'd0);
    applyStimulus();
    checkStep("jal back to fetch", 4'd0, 4'b1100);

    // illegal opcode: 0,1,0 with a one-cycle pulse in DECODE
    op = 7'b0000000;
    checkOutput("illegal low in fetch", 32'(illegal), 32'd0);
    applyStimulus();
    checkStep("illegal decode", 4'd1, 4'b0000);
    checkOutput("illegal pulse", 32'(illegal), 32'd1);
    applyStimulus();
    checkStep("illegal back to fetch", 4'd0, 4'b1100);
    checkOutput("illegal cleared", 32'(illegal), 32'd0);

    // R-type: 0,1,6,7,0
    op = 7'b0110011;
    applyStimulus();
    applyStimulus();
    checkStep("rtype execr", 4'd6, 4'b0000);
    checkOutput("rtype srcs", 32'({alu_src_a, alu_src_b, alu_op}), 32'b10_00_10);
    applyStimulus();
    checkStep("rtype aluwb", 4'd7, 4'b0001);
    applyStimulus();
    checkStep("rtype back to fetch", 4'd0, 4'b1100);

    // I-ALU: 0,1,8,7,0
    op = 7'b0010011;
    applyStimulus();
    applyStimulus();
    checkStep("itype execi", 4'd8, 4'b0000);
    checkOutput("itype srcs", 32'({alu_src_a, alu_src_b, alu_op}), 32'b10_01_10);
    applyStimulus();
    checkStep("itype aluwb", 4'd7, 4'b0001);
    applyStimulus();
    checkStep("itype back to fetch", 4'd0, 4'b1100);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Moore-style main control FSM for the multicycle RV32I core.
- Sequences the write enables of the shared datapath registers: PC, IR/OldPC, ALUOut, Data and the register file.
- Also drives the memory write strobe and the ALU, address and result multiplexer selects.
- Sits beside the datapath; takes the opcode and funct3 from IR and the ALU zero flag.

Parameters:
- STATE_W, 4, width of the state encoding and of the `state_o` debug port.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- op  input  7  `instr[6:0]` from IR.
- funct3  input  3  `instr[14:12]` from IR.
- zero  input  1  ALU zero flag, combinational from the current ALU result.
- pc_en  output  1  PC register enable.
- ir_en  output  1  IR and OldPC register enable; OldPC is written with the same enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  output  1  data memory write strobe.
- reg_write  output  1  register file write enable.
- alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = rd1.
- alu_src_b  output  2  00 = rd2, 01 = ImmExt, 10 = constant 4.
- result_src  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_op  output  2  00 = add, 01 = subtract, 10 = decode by funct.
- imm_src  output  3  immediate format select.
- illegal  output  1  one-cycle pulse on an unsupported opcode.
- state_o  output  STATE_W  current state, for debug.

Behaviour:
- Reset:
  - `resetn` = 0 forces state FETCH (0) immediately, without waiting for `clk`.
  - While `resetn` = 0: `pc_en`, `ir_en`, `mem_write`, `reg_write` and `illegal` are forced to 0; all other outputs show the FETCH values.
  - Reset in the middle of an instruction abandons it; no write strobe glitches high.
- Outputs:
  - All outputs are functions of state only, except `pc_en`, `imm_src` and `illegal`.
  - Any select not listed for a state is 00; any enable not listed is 0.
- `pc_en` = `pc_update` | (`branch` & `take`), where `take` = `zero` XOR `funct3[0]` (BEQ/BNE).
- `imm_src` decodes from `op`:
  - 0000011 / 0010011 / 1100111 → 000 (I)
  - 0100011 → 001 (S)
  - 1100011 → 010 (B)
  - 1101111 → 011 (J)
  - otherwise → 000
- States and transitions:
  - FETCH(0): `adr_src`=0, `ir_en`=1, a=00, b=10, `alu_op`=00, `result_src`=10, `pc_update`=1 → DECODE.
  - DECODE(1): a=01, b=01, `alu_op`=00. Next state by `op`:
    - 0000011 / 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BRANCH
    - other → FETCH, with `illegal`=1 for that DECODE cycle
  - MEMADR(2): a=10, b=01, `alu_op`=00 → MEMREAD if `op`=0000011, else MEMWRITE.
  - MEMREAD(3): `result_src`=00, `adr_src`=1 → MEMWB.
  - MEMWB(4): `result_src`=01, `reg_write`=1 → FETCH.
  - MEMWRITE(5): `result_src`=00, `adr_src`=1, `mem_write`=1 → FETCH.
  - EXECR(6): a=10, b=00, `alu_op`=10 → ALUWB.
  - ALUWB(7): `result_src`=00, `reg_write`=1 → FETCH.
  - EXECI(8): a=10, b=01, `alu_op`=10 → ALUWB.
  - JAL(9): a=01, b=10, `alu_op`=00, `result_src`=00, `pc_update`=1 → ALUWB.
  - BRANCH(10): a=10, b=00, `alu_op`=01, `result_src`=00, `branch`=1 → FETCH.
  - Unused encodings 11–15 → FETCH on the next edge, with all outputs in their default (idle) values.
- Cycles per instruction (FETCH to the next FETCH):
  - lw 5
  - sw 4
  - R-type 4
  - I-ALU 4
  - jal 4
  - branch 3
  - illegal 2
- `reg_write`, `mem_write` and `ir_en` are each high for exactly one cycle per instruction in the states listed above. They are never high together.

Test Plan:
- `resetn` low for 2 cycles, mid-MEMREAD → `state_o`=0 immediately; all enables 0 while low; first edge after release goes to DECODE with `ir_en`=1 in FETCH.
- `op`=0000011 (lw) → state sequence 0,1,2,3,4,0; `reg_write`=1 only in state 4 with `result_src`=01; `adr_src`=1 in state 3.
- `op`=0100011 (sw) → sequence 0,1,2,5,0; `mem_write`=1 only in state 5; `reg_write` never asserted; `imm_src`=001.
- `op`=1100011 with `funct3`=000:
  - `zero`=1 in state 10 → `pc_en`=1.
  - `zero`=0 → `pc_en`=0.
  - Repeat with `funct3`=001 → results inverted.
  - Sequence 0,1,10,0.
- `op`=1101111 (jal) → sequence 0,1,9,7,0; `pc_en`=1 in states 0 and 9; `reg_write` in 7; `imm_src`=011.
- `op`=0000000 → sequence 0,1,0 with `illegal`=1 for one cycle in state 1; no register, memory or PC write beyond FETCH.
